// File: rtl/clk_mgmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_mgmt_pkg
// Description : Shared types and default constants for reference-clock
//               qualification and source selection.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_mgmt_pkg;

    // Selector FSM states
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_HOLDOFF = 1'b1
    } sel_state_e;

    // 100 us measurement window at a 250 MHz local clock
    localparam int unsigned GATE_CYCLES_250M_100US = 25000;
    // Rising edges of a 10 MHz reference inside that window
    localparam int unsigned EXP_COUNT_10M          = 1000;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_freq_check.sv
`default_nettype none
// ============================================================================
// Module      : clk_freq_check
// Description : Per-channel reference qualification: synchronizer, windowed
//               edge counter, tolerance compare and good/bad hysteresis.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_freq_check
    import clk_mgmt_pkg::*;
#(
    parameter int unsigned EXP_COUNT    = EXP_COUNT_10M,
    parameter int unsigned TOL          = 10,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned GOOD_WINDOWS = 16,
    parameter int unsigned BAD_WINDOWS  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ref_clk_in,
    input  logic                 win_end,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 valid
);

    localparam int unsigned c_good_w = width_for(GOOD_WINDOWS + 1);
    localparam int unsigned c_bad_w  = width_for(BAD_WINDOWS + 1);
    localparam logic [c_good_w-1:0] c_good_max = c_good_w'(GOOD_WINDOWS);
    localparam logic [c_bad_w-1:0]  c_bad_max  = c_bad_w'(BAD_WINDOWS);
    // Bounds are one bit wider than the counter; the lower bound clamps at 0
    localparam logic [CNT_WIDTH:0] c_lo =
        (CNT_WIDTH+1)'((TOL >= EXP_COUNT) ? 0 : EXP_COUNT - TOL);
    localparam logic [CNT_WIDTH:0] c_hi = (CNT_WIDTH+1)'(EXP_COUNT + TOL);

    logic [2:0]           sync_q, sync_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [c_good_w-1:0]  good_run_q, good_run_d;
    logic [c_bad_w-1:0]   bad_run_q, bad_run_d;
    logic                 valid_q, valid_d;
    logic                 rise;
    logic                 win_good;
    logic [CNT_WIDTH:0]   cnt_ext;

    // Edge detect, edge counting, window publish and hysteresis update
    always_comb begin
        sync_d     = {sync_q[1:0], ref_clk_in};
        rise       = sync_q[1] & ~sync_q[2];
        cnt_ext    = {1'b0, edge_cnt_q};
        win_good   = (cnt_ext >= c_lo) && (cnt_ext <= c_hi);
        edge_cnt_d = edge_cnt_q;
        count_d    = count_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        valid_d    = valid_q;
        if (win_end) begin
            count_d    = edge_cnt_q;
            // An edge on the terminal cycle is the first of the next window
            edge_cnt_d = rise ? CNT_WIDTH'(1) : '0;
            if (win_good) begin
                bad_run_d = '0;
                if (good_run_q != c_good_max) begin
                    good_run_d = good_run_q + 1'b1;
                end
                if (good_run_d == c_good_max) begin
                    valid_d = 1'b1;
                end
            end else begin
                good_run_d = '0;
                if (bad_run_q != c_bad_max) begin
                    bad_run_d = bad_run_q + 1'b1;
                end
                if (bad_run_d == c_bad_max) begin
                    valid_d = 1'b0;
                end
            end
        end else if (rise && (edge_cnt_q != '1)) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    // State registers; the synchronizer clears to ones so a reference that is
    // already high at reset release is not mistaken for a rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            edge_cnt_q <= '0;
            count_q    <= '0;
            good_run_q <= '0;
            bad_run_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            edge_cnt_q <= edge_cnt_d;
            count_q    <= count_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            valid_q    <= valid_d;
        end
    end

    assign count = count_q;
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/clk_source_select.sv
`default_nettype none
// ============================================================================
// Module      : clk_source_select
// Description : Measures CH_COUNT reference clocks against the local clock and
//               drives the reference-mux select (auto priority or manual).
// Revision    : 1.0 - initial release
// ============================================================================
module clk_source_select
    import clk_mgmt_pkg::*;
#(
    parameter int unsigned CH_COUNT        = 2,
    parameter int unsigned GATE_CYCLES     = GATE_CYCLES_250M_100US,
    parameter int unsigned EXP_COUNT       = EXP_COUNT_10M,
    parameter int unsigned TOL             = 10,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned GOOD_WINDOWS    = 16,
    parameter int unsigned BAD_WINDOWS     = 2,
    parameter int unsigned HOLDOFF_WINDOWS = 8,
    parameter int unsigned SEL_WIDTH       = width_for(CH_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CH_COUNT-1:0]           ref_clk_in,
    input  logic                          mode_auto,
    input  logic [SEL_WIDTH-1:0]          manual_sel,
    output logic [SEL_WIDTH-1:0]          sel,
    output logic                          switch_pulse,
    output logic [CH_COUNT-1:0]           ch_valid,
    output logic [CH_COUNT*CNT_WIDTH-1:0] ch_count
);

    localparam int unsigned c_gate_w   = width_for(GATE_CYCLES);
    localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
    localparam int unsigned c_hold_w   = width_for(HOLDOFF_WINDOWS + 1);
    localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(HOLDOFF_WINDOWS);
    localparam int unsigned c_sel_span = 1 << SEL_WIDTH;
    // One extra bit so CH_COUNT == 2**SEL_WIDTH is representable
    localparam logic [SEL_WIDTH:0] c_ch_limit = (SEL_WIDTH+1)'(CH_COUNT);

    logic [c_gate_w-1:0]   gate_q, gate_d;
    logic                  win_end;
    logic                  eval_q, eval_d;
    sel_state_e            state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  switch_pulse_q, switch_pulse_d;
    logic [c_hold_w-1:0]   hold_q, hold_d;
    logic [SEL_WIDTH-1:0]  target;
    logic [c_sel_span-1:0] valid_span;

    // Shared measurement gate; evaluation follows each window end by a cycle
    always_comb begin
        win_end = (gate_q == c_gate_last);
        gate_d  = win_end ? '0 : gate_q + 1'b1;
        eval_d  = win_end;
    end

    for (genvar gi = 0; gi < int'(CH_COUNT); gi++) begin : g_ch
        clk_freq_check #(
            .EXP_COUNT    (EXP_COUNT),
            .TOL          (TOL),
            .CNT_WIDTH    (CNT_WIDTH),
            .GOOD_WINDOWS (GOOD_WINDOWS),
            .BAD_WINDOWS  (BAD_WINDOWS)
        ) u_check (
            .clk        (clk),
            .rst_n      (rst_n),
            .ref_clk_in (ref_clk_in[gi]),
            .win_end    (win_end),
            .count      (ch_count[gi*CNT_WIDTH +: CNT_WIDTH]),
            .valid      (ch_valid[gi])
        );
    end

    // Auto target: highest valid channel, channel 0 as the unconditional fallback
    always_comb begin
        target = '0;
        for (int unsigned i = 1; i < CH_COUNT; i++) begin
            if (ch_valid[i]) begin
                target = SEL_WIDTH'(i);
            end
        end
        valid_span = c_sel_span'(ch_valid);
    end

    // Selector next state: manual override, auto upgrade with holdoff, fail-fast
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        if (eval_q) begin
            if (!mode_auto) begin
                state_d = ST_RUN;
                hold_d  = '0;
                if ({1'b0, manual_sel} < c_ch_limit) begin
                    sel_d = manual_sel;
                end
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (target != sel_q) begin
                            sel_d   = target;
                            state_d = ST_HOLDOFF;
                            hold_d  = c_hold_init;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (!valid_span[sel_q] && (sel_q != '0)) begin
                            sel_d  = target;
                            hold_d = c_hold_init;
                        end else if (hold_q <= c_hold_w'(1)) begin
                            state_d = ST_RUN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q - 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        hold_d  = '0;
                    end
                endcase
            end
        end
        switch_pulse_d = (sel_d != sel_q);
    end

    // Gate, evaluation strobe and selector registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q         <= '0;
            eval_q         <= 1'b0;
            state_q        <= ST_RUN;
            sel_q          <= '0;
            switch_pulse_q <= 1'b0;
            hold_q         <= '0;
        end else begin
            gate_q         <= gate_d;
            eval_q         <= eval_d;
            state_q        <= state_d;
            sel_q          <= sel_d;
            switch_pulse_q <= switch_pulse_d;
            hold_q         <= hold_d;
        end
    end

    assign sel          = sel_q;
    assign switch_pulse = switch_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_source_select.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_clk_source_select
// Description : Directed self-checking bench for clk_source_select with
//               shortened windows (480 clk cycles, 30 expected edges).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_source_select;

    localparam int unsigned CH   = 3;
    localparam int unsigned G    = 480;
    localparam int unsigned EXP  = 30;
    localparam int unsigned TOL  = 2;
    localparam int unsigned CW   = 16;
    localparam int unsigned SW   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [CH-1:0]      ref_clk_in;
    logic               mode_auto = 1'b1;
    logic [SW-1:0]      manual_sel = '0;
    logic [SW-1:0]      sel;
    logic               switch_pulse;
    logic [CH-1:0]      ch_valid;
    logic [CH*CW-1:0]   ch_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int pulse_mark = 0;
    // Half period in ns per reference; 0 holds the line flat low
    int half [CH] = '{32, 32, 0};

    clk_source_select #(
        .CH_COUNT        (CH),
        .GATE_CYCLES     (G),
        .EXP_COUNT       (EXP),
        .TOL             (TOL),
        .CNT_WIDTH       (CW),
        .GOOD_WINDOWS    (16),
        .BAD_WINDOWS     (2),
        .HOLDOFF_WINDOWS (8),
        .SEL_WIDTH       (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ref_clk_in   (ref_clk_in),
        .mode_auto    (mode_auto),
        .manual_sel   (manual_sel),
        .sel          (sel),
        .switch_pulse (switch_pulse),
        .ch_valid     (ch_valid),
        .ch_count     (ch_count)
    );

    // 250 MHz local clock
    always #2 clk = ~clk;

    // Reference generators; the 1 ns offset keeps toggles off clk edges
    for (genvar gi = 0; gi < int'(CH); gi++) begin : g_ref
        logic r = 1'b0;
        initial begin
            #1;
            forever begin
                if (half[gi] == 0) begin
                    r = 1'b0;
                    #4;
                end else begin
                    #(half[gi]) r = ~r;
                end
            end
        end
        assign ref_clk_in[gi] = r;
    end

    // Count strobes just after each active edge
    always @(posedge clk) begin
        #1;
        if (switch_pulse === 1'b1) pulses++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_pulses(input string tag, input int exp);
        check(tag, 64'(pulses - pulse_mark), 64'(exp));
        pulse_mark = pulses;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return ch_count[ch*CW +: CW];
    endfunction

    // Sample point for window k: counts/valid updated, selector settled
    function automatic int w(input int k);
        return k * int'(G) + 1;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_pulse", 64'(switch_pulse), 64'd0);
        check("rst_valid", 64'(ch_valid), 64'd0);
        check("rst_count", 64'(ch_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        goto(100);
        check("w1_mid_count", 64'(ch_count), 64'd0);
        goto(w(1));
        check("w1_ch0_in_tol", 64'((cnt_of(0) >= EXP - TOL) && (cnt_of(0) <= EXP)), 64'd1);
        check("w1_valid", 64'(ch_valid), 64'd0);
        goto(w(2));
        check("w2_cnt0", 64'(cnt_of(0)), 64'd30);
        check("w2_cnt1", 64'(cnt_of(1)), 64'd30);
        check("w2_cnt2", 64'(cnt_of(2)), 64'd0);
        goto(w(15));
        check("w15_valid", 64'(ch_valid), 64'b000);
        check("w15_sel", 64'(sel), 64'd0);
        goto(w(16));
        check("w16_valid", 64'(ch_valid), 64'b011);
        check("w16_sel", 64'(sel), 64'd1);
        check_pulses("w16_pulses", 1);

        // ch1 dies during holdoff
        half[1] = 0;
        goto(w(17));
        check("w17_cnt1_bad", 64'(cnt_of(1) < EXP - TOL), 64'd1);
        check("w17_valid", 64'(ch_valid), 64'b011);
        check("w17_sel", 64'(sel), 64'd1);
        goto(w(18));
        check("w18_cnt1", 64'(cnt_of(1)), 64'd0);
        check("w18_valid", 64'(ch_valid), 64'b001);
        check("w18_sel", 64'(sel), 64'd0);
        check_pulses("w18_pulses", 1);

        // ch1 restored; needs full requalification
        half[1] = 32;
        goto(w(26));
        check("w26_sel", 64'(sel), 64'd0);
        goto(w(33));
        check("w33_valid", 64'(ch_valid), 64'b001);
        check_pulses("w33_pulses", 0);
        goto(w(34));
        check("w34_cnt1", 64'(cnt_of(1)), 64'd30);
        check("w34_valid", 64'(ch_valid), 64'b011);
        check("w34_sel", 64'(sel), 64'd1);
        check_pulses("w34_pulses", 1);

        // ch1 slightly fast (32 edges) stays valid
        half[1] = 30;
        goto(w(36));
        check("w36_cnt1", 64'(cnt_of(1)), 64'd32);
        check("w36_valid", 64'(ch_valid), 64'b011);
        check("w36_sel", 64'(sel), 64'd1);
        check_pulses("w36_pulses", 0);

        // ch1 too fast (40 edges) drops out after two windows
        half[1] = 24;
        goto(w(37));
        check("w37_cnt1_high", 64'(cnt_of(1) > EXP + TOL), 64'd1);
        check("w37_valid", 64'(ch_valid), 64'b011);
        goto(w(38));
        check("w38_cnt1", 64'(cnt_of(1)), 64'd40);
        check("w38_valid", 64'(ch_valid), 64'b001);
        check("w38_sel", 64'(sel), 64'd0);
        check_pulses("w38_pulses", 1);

        // Manual mode ignores validity; out-of-range request is ignored
        mode_auto  = 1'b0;
        manual_sel = 2'd1;
        half[1]    = 0;
        goto(w(39));
        check("man_sel1", 64'(sel), 64'd1);
        check_pulses("man_sel1_pulses", 1);
        manual_sel = 2'd3;
        goto(w(40));
        check("man_sel3_hold", 64'(sel), 64'd1);
        check_pulses("man_sel3_pulses", 0);
        manual_sel = 2'd2;
        goto(w(41));
        check("man_sel2", 64'(sel), 64'd2);
        check_pulses("man_sel2_pulses", 1);
        mode_auto = 1'b1;
        goto(w(42));
        check("auto_back_sel", 64'(sel), 64'd0);
        check_pulses("auto_back_pulses", 1);

        // Mid-window reset
        goto(w(42) + 100);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_sel", 64'(sel), 64'd0);
        check("mid_rst_valid", 64'(ch_valid), 64'd0);
        check("mid_rst_count", 64'(ch_count), 64'd0);
        check("mid_rst_pulse", 64'(switch_pulse), 64'd0);
        repeat (3) @(negedge clk);
        rst_n      = 1'b1;
        cyc        = 0;
        pulse_mark = pulses;
        goto(200);
        check("post_rst_mid_count", 64'(ch_count), 64'd0);
        goto(w(1));
        check("post_rst_cnt0_full", 64'((cnt_of(0) >= EXP - TOL) && (cnt_of(0) <= EXP)), 64'd1);
        check("post_rst_cnt1", 64'(cnt_of(1)), 64'd0);
        check("post_rst_valid", 64'(ch_valid), 64'd0);
        check("post_rst_sel", 64'(sel), 64'd0);
        check_pulses("post_rst_pulses", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_source_select.md
Name: clk_source_select

Overview:
- Parametrised successor to the board clock-management source switching.
- Measures CH_COUNT reference clock inputs, sampled as data, against the local clock. Qualifies each one with frequency-window and hysteresis checks.
- Drives the reference-mux select: best valid source in auto mode, or an operator choice in manual mode.
- Sits beside the clock mux. Its sel output drives the mux select; ch_valid and ch_count feed status registers.

Parameters:
- CH_COUNT, 2: number of reference inputs. Channel 0 is the failsafe source. Higher index = higher priority.
- GATE_CYCLES, 25000: clk cycles per measurement window (100 us at 250 MHz).
- EXP_COUNT, 1000: expected rising edges per window (10 MHz).
- TOL, 10: allowed |count - EXP_COUNT|.
- CNT_WIDTH, 16: edge-counter and ch_count width.
- GOOD_WINDOWS, 16: consecutive in-tolerance windows needed to set valid.
- BAD_WINDOWS, 2: consecutive out-of-tolerance windows needed to clear valid.
- HOLDOFF_WINDOWS, 8: windows after an auto switch during which further upgrades are blocked.
- SEL_WIDTH, $clog2(CH_COUNT), minimum 1: width of sel.

Ports:
- clk  in  1  local system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ref_clk_in  in  CH_COUNT  raw reference clocks, asynchronous to clk.
- mode_auto  in  1  1 = automatic selection; 0 = manual.
- manual_sel  in  SEL_WIDTH  requested channel in manual mode.
- sel  out  SEL_WIDTH  current mux select.
- switch_pulse  out  1  one-cycle strobe on every sel change.
- ch_valid  out  CH_COUNT  per-channel qualified flag.
- ch_count  out  CH_COUNT*CNT_WIDTH  last completed window edge count; channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].

Behaviour:
- Reset values: sel=0, switch_pulse=0, ch_valid=0, ch_count=0. All run counters, the gate counter and the FSM are cleared. Asserting rst_n low mid-window aborts that window immediately; no partial count is published.
- Input path: 3-flop synchronizer per channel. A rising edge is sync2 & ~sync3, giving a fixed 3-cycle latency.
- Gate counter: counts 0..GATE_CYCLES-1 and wraps. win_end is high on the terminal cycle. The gate is shared by all channels.
- Edge counter, per channel:
  - increments on each edge and saturates at all-ones;
  - at win_end, ch_count takes the counter value, and the counter reloads to 1 if an edge coincides with win_end, otherwise 0. That edge belongs to the new window.
- Tolerance check: a window is good when EXP_COUNT-TOL <= count <= EXP_COUNT+TOL, using unsigned arithmetic widened by 1 bit (no underflow when TOL > EXP_COUNT).
- Hysteresis, per channel, evaluated at win_end:
  - good window: good_run+1 (saturating), bad_run=0;
  - bad window: bad_run+1 (saturating), good_run=0;
  - ch_valid sets when good_run reaches GOOD_WINDOWS and clears when bad_run reaches BAD_WINDOWS;
  - ch_valid updates 1 cycle after win_end.
- Selector FSM, states RUN and HOLDOFF; reset enters RUN. It evaluates on the cycle after win_end, using the updated ch_valid.
  - Auto target: highest-index channel with ch_valid=1; if none, 0. Channel 0 is always eligible regardless of its own ch_valid.
  - RUN: if target != sel, sel<=target, switch_pulse=1, enter HOLDOFF with holdoff count = HOLDOFF_WINDOWS.
  - HOLDOFF: decrements once per window and returns to RUN at 0.
  - Fail-fast: in HOLDOFF, if ch_valid[sel]=0 and sel != 0, switch to target immediately and restart holdoff.
  - Manual mode: sel<=manual_sel at the next evaluation, ignoring validity and holdoff. A manual_sel >= CH_COUNT is ignored and sel holds. Entering manual mode forces RUN.
  - Returning to auto mode resumes in RUN at the next evaluation.
- switch_pulse is never asserted when sel is unchanged.

Decomposition:
- Shared package clk_mgmt_pkg holds:
  - FSM state encoding (ST_RUN, ST_HOLDOFF);
  - default window constants: GATE_CYCLES_250M_100US, EXP_COUNT_10M.
- One sub-module, clk_freq_check, instantiated per channel via generate. It contains the synchronizer, edge counter, tolerance compare and hysteresis.
  - Inputs: clk, rst_n, ref_clk_in, win_end.
  - Outputs: count, valid.
- Top level holds the gate counter and the selector FSM.

Test Plan:
- 250 MHz clk, ch0 = 10 MHz, ch1 = 10 MHz, auto mode → ch_count = 1000 on each channel; ch_valid = 2'b11 after window 16; sel 0→1 one cycle later with a single switch_pulse.
- ch1 at 10.1 MHz → counts 1010, stays valid. ch1 at 10.2 MHz → counts 1020, ch_valid[1] clears after 2 windows, sel→0.
- ch1 stopped (flat) mid-run while in HOLDOFF → count 0; after 2 windows ch_valid[1]=0 and sel=0 immediately, holdoff restarts.
- ch1 restored during holdoff → no switch back until holdoff expires and ch_valid[1] has re-qualified (16 windows).
- Manual mode, manual_sel=1 with ch1 absent → sel=1 at next evaluation. manual_sel=3 (CH_COUNT=2) → sel unchanged, no pulse.
- rst_n low mid-window for 5 cycles → all outputs return to reset values; the first published ch_count after release comes from a full window.
